// File: rtl/ref_reader_arbiter.sv
// Arbitrates one DRAM reference reader among NUM_ENGINES engines; round-robin by default,
// lowest-index fixed priority when REF_ARB_FIXED_PRIORITY_EN is defined.
module ref_reader_arbiter #(
  parameter int NUM_ENGINES = 4,
  parameter int REF_LENGTH  = 128,
  parameter int ADDR_W      = 25
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_ENGINES*ADDR_W-1:0] eng_ref_addr_in,
  input  logic [NUM_ENGINES*ADDR_W-1:0] eng_ref_length_in,
  input  logic [NUM_ENGINES-1:0]        eng_ref_info_valid_in,
  output logic [NUM_ENGINES-1:0]        eng_ref_info_ack_out,
  output logic [2*REF_LENGTH-1:0]       eng_ref_seq_block_out,
  output logic [NUM_ENGINES-1:0]        eng_ref_seq_block_valid_out,
  input  logic [NUM_ENGINES-1:0]        eng_ref_seq_block_rdy_in,
  output logic [ADDR_W-1:0]             rd_addr_out,
  output logic [ADDR_W-1:0]             rd_length_out,
  output logic                          rd_info_valid_out,
  input  logic                          rd_info_rdy_in,
  input  logic [2*REF_LENGTH-1:0]       rd_block_in,
  input  logic                          rd_block_valid_in,
  output logic                          rd_block_rdy_out,
  output logic [NUM_ENGINES-1:0]        grant_out,
  output logic                          busy_out
);

  localparam int GW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, STREAM} state_t;

  state_t                 state_q, state_d;
  logic [GW-1:0]          gidx_q, gidx_d;
  logic [NUM_ENGINES-1:0] grant_q, grant_d;
  logic [NUM_ENGINES-1:0] ack_q, ack_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      len_q, len_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;
  logic                   rdv_q, rdv_d;
`ifndef REF_ARB_FIXED_PRIORITY_EN
  logic [GW-1:0]          last_q, last_d;
`endif

  logic          win_found;
  logic [GW-1:0] win_idx;
  logic          in_stream;
  logic          xfer;

  // Winner search: first pending request starting after the last winner (or at 0).
  always_comb begin
    int cand;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
`ifdef REF_ARB_FIXED_PRIORITY_EN
      cand = k;
`else
      cand = (int'(last_q) + 1 + k) % NUM_ENGINES;
`endif
      if (!win_found && eng_ref_info_valid_in[cand]) begin
        win_found = 1'b1;
        win_idx   = GW'(cand);
      end
    end
  end

  assign in_stream = (state_q == STREAM);
  assign xfer      = in_stream & rd_block_valid_in & eng_ref_seq_block_rdy_in[gidx_q];

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    ack_d   = '0;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    rdv_d   = rdv_q;
`ifndef REF_ARB_FIXED_PRIORITY_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          gidx_d  = win_idx;
          grant_d = {{(NUM_ENGINES-1){1'b0}}, 1'b1} << win_idx;
          ack_d   = {{(NUM_ENGINES-1){1'b0}}, 1'b1} << win_idx;
          addr_d  = eng_ref_addr_in[win_idx*ADDR_W +: ADDR_W];
          len_d   = eng_ref_length_in[win_idx*ADDR_W +: ADDR_W];
          rdv_d   = (eng_ref_length_in[win_idx*ADDR_W +: ADDR_W] != '0);
          state_d = ISSUE;
`ifndef REF_ARB_FIXED_PRIORITY_EN
          last_d  = win_idx;
`endif
        end
      end
      ISSUE: begin
        // A zero-length request spends this one cycle here and never reaches the reader.
        if (len_q == '0) begin
          grant_d = '0;
          state_d = IDLE;
        end else if (rdv_q && rd_info_rdy_in) begin
          rdv_d   = 1'b0;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rdv_q   <= 1'b0;
`ifndef REF_ARB_FIXED_PRIORITY_EN
      last_q  <= GW'(NUM_ENGINES - 1);
`endif
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rdv_q   <= rdv_d;
`ifndef REF_ARB_FIXED_PRIORITY_EN
      last_q  <= last_d;
`endif
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_valid
      assign eng_ref_seq_block_valid_out[gi] = in_stream & rd_block_valid_in & grant_q[gi];
    end
  endgenerate

  assign eng_ref_seq_block_out = in_stream ? rd_block_in : '0;
  assign rd_block_rdy_out      = in_stream & eng_ref_seq_block_rdy_in[gidx_q];
  assign eng_ref_info_ack_out  = ack_q;
  assign rd_addr_out           = addr_q;
  assign rd_length_out         = len_q;
  assign rd_info_valid_out     = rdv_q;
  assign grant_out             = grant_q;
  assign busy_out              = (state_q != IDLE);

endmodule

// File: tb/tb_ref_reader_arbiter.sv
// Directed bench for ref_reader_arbiter; delivered blocks are checked against a scoreboard queue.
module tb_ref_reader_arbiter;

  localparam int NE = 4;
  localparam int AW = 25;
  localparam int BW = 256;

  logic            clk;
  logic            rst;
  logic [NE*AW-1:0] eng_ref_addr_in;
  logic [NE*AW-1:0] eng_ref_length_in;
  logic [NE-1:0]   eng_ref_info_valid_in;
  logic [NE-1:0]   eng_ref_info_ack_out;
  logic [BW-1:0]   eng_ref_seq_block_out;
  logic [NE-1:0]   eng_ref_seq_block_valid_out;
  logic [NE-1:0]   eng_ref_seq_block_rdy_in;
  logic [AW-1:0]   rd_addr_out;
  logic [AW-1:0]   rd_length_out;
  logic            rd_info_valid_out;
  logic            rd_info_rdy_in;
  logic [BW-1:0]   rd_block_in;
  logic            rd_block_valid_in;
  logic            rd_block_rdy_out;
  logic [NE-1:0]   grant_out;
  logic            busy_out;

  ref_reader_arbiter #(.NUM_ENGINES(NE), .REF_LENGTH(128), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .eng_ref_addr_in(eng_ref_addr_in),
    .eng_ref_length_in(eng_ref_length_in),
    .eng_ref_info_valid_in(eng_ref_info_valid_in),
    .eng_ref_info_ack_out(eng_ref_info_ack_out),
    .eng_ref_seq_block_out(eng_ref_seq_block_out),
    .eng_ref_seq_block_valid_out(eng_ref_seq_block_valid_out),
    .eng_ref_seq_block_rdy_in(eng_ref_seq_block_rdy_in),
    .rd_addr_out(rd_addr_out),
    .rd_length_out(rd_length_out),
    .rd_info_valid_out(rd_info_valid_out),
    .rd_info_rdy_in(rd_info_rdy_in),
    .rd_block_in(rd_block_in),
    .rd_block_valid_in(rd_block_valid_in),
    .rd_block_rdy_out(rd_block_rdy_out),
    .grant_out(grant_out),
    .busy_out(busy_out)
  );

  typedef struct packed {
    logic [1:0]    eng;
    logic [BW-1:0] data;
  } blk_t;

  blk_t exp_q[$];
  int   n_vec;
  int   n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard consumer: every observed engine-side transfer must match the next pushed block.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NE; i++) begin
        if (eng_ref_seq_block_valid_out[i] && eng_ref_seq_block_rdy_in[i]) begin
          check("blk_expected", BW'(exp_q.size() != 0), BW'(1));
          if (exp_q.size() != 0) begin
            blk_t e;
            e = exp_q.pop_front();
            check("blk_engine", BW'(i), BW'(e.eng));
            check("blk_data", eng_ref_seq_block_out, e.data);
          end
        end
      end
    end
  end

  // Drives reader blocks in STREAM; pat[c] is the granted engine's ready in cycle c.
  task automatic run_stream(input int eng, input int n, input logic [15:0] pat);
    int sent;
    sent = 0;
    for (int c = 0; c < 16 && sent < n; c++) begin
      logic [BW-1:0] d;
      d = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      rd_block_in = d;
      rd_block_valid_in = 1'b1;
      eng_ref_seq_block_rdy_in = 4'hF;
      eng_ref_seq_block_rdy_in[eng] = pat[c];
      if (pat[c]) begin
        exp_q.push_back('{eng: 2'(eng), data: d});
        sent++;
      end
      #1;
      check("blk_rdy", BW'(rd_block_rdy_out), BW'(pat[c]));
      check("blk_valid_route", BW'(eng_ref_seq_block_valid_out), BW'(4'b0001 << eng));
      tick();
    end
  endtask

  initial begin
    int exp_e;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    eng_ref_addr_in = '0;
    eng_ref_length_in = '0;
    eng_ref_info_valid_in = '0;
    eng_ref_seq_block_rdy_in = '0;
    rd_info_rdy_in = 1'b0;
    rd_block_in = '0;
    rd_block_valid_in = 1'b0;
    #2;
    check("rst_grant", BW'(grant_out), BW'(0));
    check("rst_busy", BW'(busy_out), BW'(0));
    check("rst_ack", BW'(eng_ref_info_ack_out), BW'(0));
    check("rst_rd_valid", BW'(rd_info_valid_out), BW'(0));
    check("rst_rd_addr", BW'(rd_addr_out), BW'(0));
    check("rst_rd_len", BW'(rd_length_out), BW'(0));
    check("rst_blk_rdy", BW'(rd_block_rdy_out), BW'(0));
    tick();
    tick();
    rst = 1'b0;

    // Fairness: all engines request len=1 continuously.
    rd_info_rdy_in = 1'b1;
    for (int i = 0; i < NE; i++) begin
      eng_ref_addr_in[i*AW +: AW] = AW'(32'h40 + i * 16);
      eng_ref_length_in[i*AW +: AW] = AW'(1);
    end
    eng_ref_info_valid_in = 4'hF;
    for (int k = 0; k < 5; k++) begin
`ifdef REF_ARB_FIXED_PRIORITY_EN
      exp_e = 0;
`else
      exp_e = k % NE;
`endif
      tick();
      check("fair_ack", BW'(eng_ref_info_ack_out), BW'(4'b0001 << exp_e));
      check("fair_grant", BW'(grant_out), BW'(4'b0001 << exp_e));
      check("fair_addr", BW'(rd_addr_out), BW'(32'h40 + exp_e * 16));
      tick();
      run_stream(exp_e, 1, 16'hFFFF);
      rd_block_valid_in = 1'b0;
      #1;
      check("fair_idle_grant", BW'(grant_out), BW'(0));
    end
    eng_ref_info_valid_in = '0;
    tick();

    // Single request from engine 1 with a two-cycle engine stall.
    eng_ref_addr_in[1*AW +: AW] = AW'(32'h100);
    eng_ref_length_in[1*AW +: AW] = AW'(3);
    eng_ref_info_valid_in = 4'b0010;
    #1;
    check("single_ack_early", BW'(eng_ref_info_ack_out), BW'(0));
    tick();
    check("single_ack", BW'(eng_ref_info_ack_out), BW'(4'b0010));
    check("single_grant", BW'(grant_out), BW'(4'b0010));
    check("single_addr", BW'(rd_addr_out), BW'(32'h100));
    check("single_len", BW'(rd_length_out), BW'(3));
    check("single_rdv", BW'(rd_info_valid_out), BW'(1));
    eng_ref_info_valid_in = '0;
    tick();
    check("single_ack_pulse", BW'(eng_ref_info_ack_out), BW'(0));
    run_stream(1, 3, 16'b0000_0000_0001_1001);
    #1;
    check("single_done_grant", BW'(grant_out), BW'(0));
    check("stray_idle_rdy", BW'(rd_block_rdy_out), BW'(0));
    check("stray_idle_valid", BW'(eng_ref_seq_block_valid_out), BW'(0));

    // Zero-length request from engine 2.
    eng_ref_addr_in[2*AW +: AW] = AW'(32'h222);
    eng_ref_length_in[2*AW +: AW] = AW'(0);
    eng_ref_info_valid_in = 4'b0100;
    tick();
    check("zero_ack", BW'(eng_ref_info_ack_out), BW'(4'b0100));
    check("zero_rdv", BW'(rd_info_valid_out), BW'(0));
    check("zero_busy", BW'(busy_out), BW'(1));
    eng_ref_info_valid_in = '0;
    tick();
    check("zero_idle_busy", BW'(busy_out), BW'(0));
    check("zero_idle_grant", BW'(grant_out), BW'(0));
    check("zero_rdv_after", BW'(rd_info_valid_out), BW'(0));

    // Reader back-pressure, stray blocks in ISSUE, fields changed after grant.
    rd_info_rdy_in = 1'b0;
    eng_ref_addr_in[0*AW +: AW] = AW'(32'h1ABCDEF);
    eng_ref_length_in[0*AW +: AW] = AW'(2);
    eng_ref_info_valid_in = 4'b0001;
    tick();
    eng_ref_info_valid_in = '0;
    eng_ref_addr_in[0*AW +: AW] = AW'(5);
    eng_ref_length_in[0*AW +: AW] = AW'(7);
    rd_block_valid_in = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_rdv", BW'(rd_info_valid_out), BW'(1));
      check("bp_addr", BW'(rd_addr_out), BW'(32'h1ABCDEF));
      check("bp_len", BW'(rd_length_out), BW'(2));
      check("stray_issue_rdy", BW'(rd_block_rdy_out), BW'(0));
      check("stray_issue_valid", BW'(eng_ref_seq_block_valid_out), BW'(0));
      tick();
    end
    rd_info_rdy_in = 1'b1;
    tick();
    check("bp_rdv_clear", BW'(rd_info_valid_out), BW'(0));
    run_stream(0, 2, 16'hFFFF);

    // Reset after 2 of 5 blocks, then a fresh engine 3 request.
    eng_ref_addr_in[1*AW +: AW] = AW'(32'h300);
    eng_ref_length_in[1*AW +: AW] = AW'(5);
    eng_ref_info_valid_in = 4'b0010;
    rd_block_valid_in = 1'b0;
    tick();
    eng_ref_info_valid_in = '0;
    tick();
    run_stream(1, 2, 16'hFFFF);
    check("mid_busy", BW'(busy_out), BW'(1));
    rst = 1'b1;
    #1;
    check("mrst_grant", BW'(grant_out), BW'(0));
    check("mrst_busy", BW'(busy_out), BW'(0));
    check("mrst_blk_rdy", BW'(rd_block_rdy_out), BW'(0));
    check("mrst_valid", BW'(eng_ref_seq_block_valid_out), BW'(0));
    check("mrst_addr", BW'(rd_addr_out), BW'(0));
    check("mrst_len", BW'(rd_length_out), BW'(0));
    tick();
    rst = 1'b0;
    rd_block_valid_in = 1'b0;
    eng_ref_addr_in[3*AW +: AW] = AW'(32'h333);
    eng_ref_length_in[3*AW +: AW] = AW'(2);
    eng_ref_info_valid_in = 4'b1000;
    tick();
    check("post_ack", BW'(eng_ref_info_ack_out), BW'(4'b1000));
    check("post_addr", BW'(rd_addr_out), BW'(32'h333));
    eng_ref_info_valid_in = '0;
    tick();
    run_stream(3, 2, 16'hFFFF);
    rd_block_valid_in = 1'b0;
    #1;
    check("post_grant", BW'(grant_out), BW'(0));
    check("post_busy", BW'(busy_out), BW'(0));
    tick();
    check("sb_empty", BW'(exp_q.size()), BW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ref_reader_arbiter.md
# ref_reader_arbiter

Shares one DRAM reference-sequence reader between `NUM_ENGINES` Smith-Waterman engines. Each engine posts a reference request (DRAM address plus block count). The arbiter grants one engine at a time, forwards that request to the reader, and routes the returned reference blocks to the granted engine. It releases the grant after the last block. It sits between the engines' `ref_*` ports and the single DRAM reference reader.

## Interface
- `NUM_ENGINES`, 4: number of requesting engines (≥2).
- `REF_LENGTH`, 128: bases per reference block; the block bus is `2*REF_LENGTH` bits.
- `ADDR_W`, 25: width of the address and length fields.

- `clk` in 1: engine clock.
- `rst` in 1: system reset, asynchronous, active-high.
- `eng_ref_addr_in` in `NUM_ENGINES*ADDR_W`: per-engine start address; engine i occupies slice `[i*ADDR_W +: ADDR_W]`.
- `eng_ref_length_in` in `NUM_ENGINES*ADDR_W`: per-engine block count, same slicing.
- `eng_ref_info_valid_in` in `NUM_ENGINES`: request pending. The engine holds it and its fields stable until acked.
- `eng_ref_info_ack_out` out `NUM_ENGINES`: one-cycle pulse; the request has been captured.
- `eng_ref_seq_block_out` out `2*REF_LENGTH`: block data, broadcast to all engines.
- `eng_ref_seq_block_valid_out` out `NUM_ENGINES`: block valid, asserted only on the granted engine's bit.
- `eng_ref_seq_block_rdy_in` in `NUM_ENGINES`: per-engine block ready.
- `rd_addr_out` out `ADDR_W`: address forwarded to the reader (registered).
- `rd_length_out` out `ADDR_W`: length forwarded to the reader (registered).
- `rd_info_valid_out` out 1: forwarded request valid.
- `rd_info_rdy_in` in 1: reader accepts the request.
- `rd_block_in` in `2*REF_LENGTH`: block from the reader.
- `rd_block_valid_in` in 1: reader block valid.
- `rd_block_rdy_out` out 1: block accepted.
- `grant_out` out `NUM_ENGINES`: one-hot current grant; all zero when idle.
- `busy_out` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, ISSUE, STREAM.
- **IDLE**
  - When any `eng_ref_info_valid_in` bit is set, select a winner. In round-robin order the search starts at (last winner + 1) mod `NUM_ENGINES`.
  - At the next edge: register `grant_out`, `rd_addr_out` and `rd_length_out` from the winner's slice, and pulse the winner's ack bit for one cycle.
  - Length ≠ 0: go to ISSUE.
  - Length = 0: the request is acked but not forwarded; `grant_out` clears and the state returns to IDLE on the following edge. The round-robin pointer still advances.
- **ISSUE**
  - Hold `rd_info_valid_out`=1 and the address/length fields stable.
  - On `rd_info_valid_out & rd_info_rdy_in`: clear the block counter and go to STREAM.
- **STREAM**
  - Pass-through paths:
    - `eng_ref_seq_block_out` = `rd_block_in`.
    - `eng_ref_seq_block_valid_out[g]` = `rd_block_valid_in`, where g is the granted engine.
    - `rd_block_rdy_out` = `eng_ref_seq_block_rdy_in[g]`.
  - A transfer occurs when valid and rdy are both high; each transfer increments the `ADDR_W`-bit counter.
  - On the transfer where counter == length−1: go to IDLE, clear `grant_out`, and update the round-robin pointer to g.
- **Outside STREAM:** `rd_block_rdy_out`=0 and every `eng_ref_seq_block_valid_out` bit is 0. Stray reader blocks are back-pressured, never dropped or misrouted.
- **Request-valid changes:** `eng_ref_info_valid_in` is ignored outside IDLE. Ungranted requests wait and are not acked.
- **Fields:** `eng_ref_length_in` and `eng_ref_addr_in` are sampled only at grant; later changes have no effect.

## Timing
- **Reset values:** all outputs are 0, state is IDLE, and the round-robin pointer selects engine 0 first.
- **Reset mid-transfer:** reset asserted in ISSUE or STREAM forces IDLE asynchronously. The partial transfer is abandoned; the reader must be reset by the same `rst`.
- **Request to ack and `rd_info_valid_out`:** 1 cycle (registered).
- **Request to ack, zero-length request:** 1 cycle. The next grant can occur no earlier than 2 cycles after that ack.
- **Block path:** 0 cycles, combinational valid/rdy/data.
- **Back-to-back grants:** one IDLE cycle between the last block transfer and the next grant.
- **Simultaneous requests:** resolved by round-robin (or fixed priority, see Configuration). Exactly one ack bit pulses per grant.
- **Counter:** compares against the full `ADDR_W` length with no wrap. The maximum length, 2^ADDR_W−1, is supported.

## Configuration
- `REF_ARB_FIXED_PRIORITY_EN` defined: fixed priority, lowest engine index wins; the round-robin pointer is not implemented.
- `REF_ARB_FIXED_PRIORITY_EN` undefined (default): round-robin as described in Operation.

## Test plan
- **Single request, stalled engine:** engine 1 requests addr=0x100, len=3; reader rdy immediate; engine 1 rdy low for 2 cycles mid-stream.
  - Ack[1] pulses 1 cycle after request.
  - `rd_addr_out`=0x100 and `rd_length_out`=3.
  - Exactly 3 blocks reach only engine 1; `rd_block_rdy_out` is low during the stall.
  - `grant_out`=0 after the 3rd transfer.
- **Fairness:** all 4 engines request continuously with len=1 each.
  - Grants go 0,1,2,3,0 under round-robin.
  - With `REF_ARB_FIXED_PRIORITY_EN` defined and engine 0 re-requesting immediately, engine 0 repeatedly wins.
- **Zero length:** engine 2 requests len=0.
  - Ack[2] pulses; `rd_info_valid_out` never rises.
  - The FSM returns to IDLE 2 cycles after the request.
- **Stray blocks:** `rd_block_valid_in`=1 while in IDLE and ISSUE.
  - `rd_block_rdy_out`=0 and all engine valid bits are 0.
- **Reset mid-operation:** assert `rst` after 2 of 5 blocks.
  - All outputs go to 0 immediately.
  - A new engine 3 request after reset is granted and completes normally.
- **Reader back-pressure:** hold `rd_info_rdy_in` low for 5 cycles.
  - `rd_info_valid_out`, `rd_addr_out` and `rd_length_out` stay stable.
  - STREAM is entered on the cycle after rdy rises.
